jtag_host: RTL and testbench

- Host-side JTAG driver. Generates TCK/TMS/TDI and samples TDO to run complete instruction (IR) and data (DR) scans against the processor's 3-bit-state JTAG debug port.
- Sits in the programming/bring-up harness, driven by a controller such as a UART bridge or a test sequencer.
- One request produces one full scan. Each scan starts and ends with the port in IDLE.
- Memory access is a composite of scans issued by the controller: DR scan (address or data), then IR scan (command).

---
 rtl/jtag_host_if.sv | 26 ++
 rtl/jtag_host.sv | 164 ++++++++++++++++
 tb/tb_jtag_host.sv | 397 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jtag_host_if.sv
// Request/response and JTAG pin bundle for the jtag_host scan engine.
// Handshake: i_start is taken only on an i_clk edge where o_busy=0; o_busy
// then stays high for the whole scan, and o_done pulses for one cycle (busy=0) at the end.
interface jtag_host_if;
    logic        i_start;
    logic        i_isData;
    logic [15:0] i_wrData;
    logic [15:0] o_rdData;
    logic        o_busy;
    logic        o_done;
    logic        o_TCK;
    logic        o_TMS;
    logic        o_TDI;
    logic        i_TDO;
    logic [1:0]  o_state;

    modport master (
        output i_start, i_isData, i_wrData, i_TDO,
        input  o_rdData, o_busy, o_done, o_TCK, o_TMS, o_TDI, o_state
    );

    modport slave (
        input  i_start, i_isData, i_wrData, i_TDO,
        output o_rdData, o_busy, o_done, o_TCK, o_TMS, o_TDI, o_state
    );
endinterface

// File: rtl/jtag_host.sv
// Host-side JTAG driver: runs one complete 8-bit IR or 16-bit DR scan per
// request against the 3-bit-state debug port, starting and ending in IDLE.
module jtag_host #(
    parameter int CLK_DIV = 4
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    jtag_host_if.slave  bus
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [4:0] IR_LAST = 5'd10;
    localparam logic [4:0] DR_LAST = 5'd18;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOW  = 2'd1,
        S_HIGH = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [4:0]       pulse_q, pulse_d;
    logic             is_data_q, is_data_d;
    logic [15:0]      wr_q, wr_d;
    logic [15:0]      rd_q, rd_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             tck_q, tck_d;
    logic             tms_q, tms_d;
    logic             tdi_q, tdi_d;

    // {TMS,TDI} for pulse p (0-based); payload goes out MSB first.
    function automatic logic [1:0] scan_pattern(input logic is_data,
                                                input logic [4:0] p,
                                                input logic [15:0] wr);
        logic [3:0] bidx;
        logic [1:0] pat;
        pat  = 2'b00;
        bidx = '0;
        if (is_data) begin
            bidx = 4'(5'd18 - p);
            if (p <= 5'd1)                    pat = 2'b10;
            else if (p >= 5'd3 && p <= 5'd17) pat = {1'b0, wr[bidx]};
            else if (p == 5'd18)              pat = {1'b1, wr[0]};
        end else begin
            bidx = 4'(5'd9 - p);
            if (p == 5'd0)                    pat = 2'b10;
            else if (p >= 5'd2 && p <= 5'd8)  pat = {1'b0, wr[bidx]};
            else if (p == 5'd9)               pat = {1'b1, wr[0]};
        end
        return pat;
    endfunction

    logic       sample_tdo;
    logic       last_pulse;
    logic [4:0] pulse_nxt;

    always_comb begin
        sample_tdo = is_data_q ? (pulse_q >= 5'd3)
                               : (pulse_q >= 5'd2 && pulse_q <= 5'd9);
        last_pulse = (pulse_q == (is_data_q ? DR_LAST : IR_LAST));
        pulse_nxt  = pulse_q + 5'd1;
    end

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        pulse_d   = pulse_q;
        is_data_d = is_data_q;
        wr_d      = wr_q;
        rd_d      = rd_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        tck_d     = tck_q;
        tms_d     = tms_q;
        tdi_d     = tdi_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (bus.i_start && !busy_q) begin
                    state_d          = S_LOW;
                    is_data_d        = bus.i_isData;
                    wr_d             = bus.i_wrData;
                    rd_d             = '0;
                    busy_d           = 1'b1;
                    pulse_d          = '0;
                    div_d            = '0;
                    tck_d            = 1'b0;
                    {tms_d, tdi_d}   = scan_pattern(bus.i_isData, 5'd0, bus.i_wrData);
                end
            end
            S_LOW: begin
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    tck_d   = 1'b1;
                    state_d = S_HIGH;
                    // TDO is taken before the target sees this rising edge.
                    if (sample_tdo) rd_d = {rd_q[14:0], bus.i_TDO};
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            S_HIGH: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    tck_d = 1'b0;
                    if (last_pulse) begin
                        state_d = S_DONE;
                        tms_d   = 1'b0;
                        tdi_d   = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d        = S_LOW;
                        pulse_d        = pulse_nxt;
                        {tms_d, tdi_d} = scan_pattern(is_data_q, pulse_nxt, wr_q);
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            pulse_q   <= '0;
            is_data_q <= 1'b0;
            wr_q      <= '0;
            rd_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            tck_q     <= 1'b0;
            tms_q     <= 1'b0;
            tdi_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            pulse_q   <= pulse_d;
            is_data_q <= is_data_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            tck_q     <= tck_d;
            tms_q     <= tms_d;
            tdi_q     <= tdi_d;
        end
    end

    assign bus.o_rdData = rd_q;
    assign bus.o_busy   = busy_q;
    assign bus.o_done   = done_q;
    assign bus.o_TCK    = tck_q;
    assign bus.o_TMS    = tms_q;
    assign bus.o_TDI    = tdi_q;
    assign bus.o_state  = state_q;
endmodule

// File: tb/tb_jtag_host.sv
// Bench for jtag_host: a debug-port target model on the CLK_DIV=4 instance,
// TDO tied high on a CLK_DIV=1 instance, scoreboard queues checked at o_done.
module tb_jtag_host;
    logic clk;
    logic rstn;
    int   total;
    int   bad;

    jtag_host_if a_if ();
    jtag_host_if b_if ();

    jtag_host #(.CLK_DIV(4)) u_a (.i_clk(clk), .i_rstn(rstn), .bus(a_if));
    jtag_host #(.CLK_DIV(1)) u_b (.i_clk(clk), .i_rstn(rstn), .bus(b_if));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    // ---------------- target model (3-bit-state debug port) ----------------
    typedef enum logic [2:0] {
        M_IDLE, M_ISEL, M_ISHFT, M_UPD, M_DSEL, M_DSHFT
    } m_state_t;
    localparam logic [7:0] M_STATUS = 8'h03;

    m_state_t    m_st;
    logic [7:0]  m_ir_sr;
    logic [15:0] m_dr_sr;
    logic [15:0] m_data;
    logic [15:0] m_addr;
    logic [15:0] m_wr_addr;
    logic [15:0] m_wr_data;
    logic [7:0]  m_wr_cnt;
    logic [15:0] m_mem [0:255];
    logic        m_tdo;
    logic [7:0]  m_cmd;

    always_comb begin
        m_cmd = {m_ir_sr[6:0], a_if.o_TDI};
        m_tdo = 1'b0;
        if (m_st == M_ISHFT) m_tdo = m_ir_sr[7];
        else if (m_st == M_DSHFT) m_tdo = m_dr_sr[15];
    end
    assign a_if.i_TDO = m_tdo;
    assign b_if.i_TDO = 1'b1;

    always @(posedge a_if.o_TCK or negedge rstn) begin
        if (!rstn) begin
            m_st      <= M_IDLE;
            m_ir_sr   <= '0;
            m_dr_sr   <= '0;
            m_data    <= '0;
            m_addr    <= '0;
            m_wr_addr <= '0;
            m_wr_data <= '0;
            m_wr_cnt  <= '0;
        end else begin
            case (m_st)
                M_IDLE: if (a_if.o_TMS) m_st <= M_ISEL;
                M_ISEL: begin
                    if (a_if.o_TMS) m_st <= M_DSEL;
                    else begin
                        m_st    <= M_ISHFT;
                        m_ir_sr <= M_STATUS;
                    end
                end
                M_ISHFT: begin
                    m_ir_sr <= m_cmd;
                    if (a_if.o_TMS) begin
                        m_st <= M_UPD;
                        case (m_cmd)
                            8'h01: m_addr <= m_data;
                            8'h02: m_data <= m_mem[m_addr[7:0]];
                            8'h03: begin
                                m_mem[m_addr[7:0]] <= m_data;
                                m_wr_cnt  <= m_wr_cnt + 8'd1;
                                m_wr_addr <= m_addr;
                                m_wr_data <= m_data;
                            end
                            default: ;
                        endcase
                    end
                end
                M_UPD: if (!a_if.o_TMS) m_st <= M_IDLE;
                M_DSEL: begin
                    if (!a_if.o_TMS) begin
                        m_st    <= M_DSHFT;
                        m_dr_sr <= m_data;
                    end
                end
                M_DSHFT: begin
                    m_dr_sr <= {m_dr_sr[14:0], a_if.o_TDI};
                    if (a_if.o_TMS) begin
                        m_data <= {m_dr_sr[14:0], a_if.o_TDI};
                        m_st   <= M_IDLE;
                    end
                end
                default: m_st <= M_IDLE;
            endcase
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [15:0] rd;
        logic [7:0]  edges;
        logic [31:0] tms;
        logic [31:0] tdi;
        logic [15:0] busy;
    } exp_a_t;
    typedef struct packed {
        logic [15:0] rd;
        logic [7:0]  edges;
        logic [15:0] busy;
    } exp_b_t;

    exp_a_t exp_q[$];
    exp_b_t exp_b_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Monitor for the CLK_DIV=4 instance.
    logic [7:0]  a_edges;
    logic [15:0] a_busy;
    logic [31:0] a_tms, a_tdi;
    logic        a_prev;
    exp_a_t      ea;

    initial begin
        a_edges = '0; a_busy = '0; a_tms = '0; a_tdi = '0; a_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                a_edges = '0; a_busy = '0; a_tms = '0; a_tdi = '0;
            end else begin
                if (a_if.o_TCK && !a_prev) begin
                    a_edges = a_edges + 8'd1;
                    a_tms   = {a_tms[30:0], a_if.o_TMS};
                    a_tdi   = {a_tdi[30:0], a_if.o_TDI};
                end
                if (a_if.o_busy) a_busy = a_busy + 16'd1;
                if (a_if.o_done) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL a_unexpected_done: got done=1 want no scan pending");
                    end else begin
                        ea = exp_q.pop_front();
                        check("a_rd", 32'(a_if.o_rdData), 32'(ea.rd));
                        check("a_edges", 32'(a_edges), 32'(ea.edges));
                        check("a_tms", a_tms, ea.tms);
                        check("a_tdi", a_tdi, ea.tdi);
                        check("a_busy_cycles", 32'(a_busy), 32'(ea.busy));
                        check("a_done_busy", 32'(a_if.o_busy), 32'd0);
                    end
                    a_edges = '0; a_busy = '0; a_tms = '0; a_tdi = '0;
                end
            end
            a_prev = rstn ? a_if.o_TCK : 1'b0;
        end
    end

    // Monitor for the CLK_DIV=1 instance.
    logic [7:0]  b_edges;
    logic [15:0] b_busy;
    logic        b_prev;
    exp_b_t      eb;

    initial begin
        b_edges = '0; b_busy = '0; b_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                b_edges = '0; b_busy = '0;
            end else begin
                if (b_if.o_TCK && !b_prev) b_edges = b_edges + 8'd1;
                if (b_if.o_busy) b_busy = b_busy + 16'd1;
                if (b_if.o_done) begin
                    if (exp_b_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL b_unexpected_done: got done=1 want no scan pending");
                    end else begin
                        eb = exp_b_q.pop_front();
                        check("b_rd", 32'(b_if.o_rdData), 32'(eb.rd));
                        check("b_edges", 32'(b_edges), 32'(eb.edges));
                        check("b_busy_cycles", 32'(b_busy), 32'(eb.busy));
                    end
                    b_edges = '0; b_busy = '0;
                end
            end
            b_prev = rstn ? b_if.o_TCK : 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    // Hand-derived pin images: IR TMS 1,0,0,0,0,0,0,0,0,1,0 and
    // DR TMS 1,1,0,(15x0),1; TDI is zeros around the payload sent MSB first.
    task automatic push_a(input logic d, input logic [15:0] wr, input logic [15:0] exp_rd);
        exp_a_t e;
        e.rd    = exp_rd;
        e.edges = d ? 8'd19 : 8'd11;
        e.tms   = d ? 32'h0006_0001 : 32'h0000_0402;
        e.tdi   = d ? {16'h0, wr} : {21'h0, 2'b00, wr[7:0], 1'b0};
        e.busy  = d ? 16'd152 : 16'd88;
        exp_q.push_back(e);
    endtask

    task automatic issue_a(input logic d, input logic [15:0] wr, input logic [15:0] exp_rd);
        push_a(d, wr, exp_rd);
        a_if.i_isData = d;
        a_if.i_wrData = wr;
        a_if.i_start  = 1'b1;
        @(negedge clk);
        a_if.i_start  = 1'b0;
    endtask

    task automatic wait_done_a();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (a_if.o_done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL a_timeout: got no done want done within 400 cycles");
        end
    endtask

    task automatic scan_a(input logic d, input logic [15:0] wr, input logic [15:0] exp_rd);
        @(negedge clk);
        issue_a(d, wr, exp_rd);
        wait_done_a();
    endtask

    task automatic scan_b(input logic d, input logic [15:0] wr, input logic [15:0] exp_rd,
                          input logic [15:0] exp_busy);
        exp_b_t e;
        bit seen;
        e.rd    = exp_rd;
        e.edges = d ? 8'd19 : 8'd11;
        e.busy  = exp_busy;
        exp_b_q.push_back(e);
        @(negedge clk);
        b_if.i_isData = d;
        b_if.i_wrData = wr;
        b_if.i_start  = 1'b1;
        @(negedge clk);
        b_if.i_start  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (b_if.o_done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL b_timeout: got no done want done within 200 cycles");
        end
    endtask

    // ---------------- stimulus ----------------
    int   busy_seen;
    int   rises;
    logic prev_tck;
    bit   seen_done;

    initial begin
        total = 0;
        bad   = 0;
        rstn  = 1'b0;
        a_if.i_start = 1'b0; a_if.i_isData = 1'b0; a_if.i_wrData = '0;
        b_if.i_start = 1'b0; b_if.i_isData = 1'b0; b_if.i_wrData = '0;
        repeat (3) @(negedge clk);

        check("rst_tck", 32'(a_if.o_TCK), 32'd0);
        check("rst_tms", 32'(a_if.o_TMS), 32'd0);
        check("rst_tdi", 32'(a_if.o_TDI), 32'd0);
        check("rst_busy", 32'(a_if.o_busy), 32'd0);
        check("rst_done", 32'(a_if.o_done), 32'd0);
        check("rst_rd", 32'(a_if.o_rdData), 32'd0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // IR 0x03 with status paused+booted.
        scan_a(1'b0, 16'h0003, 16'h0003);
        // DR preload 0x1234, then DR 0xA5C3 reads it back.
        scan_a(1'b1, 16'h1234, 16'h0000);
        scan_a(1'b1, 16'hA5C3, 16'h1234);
        check("model_data", 32'(m_data), 32'h0000_A5C3);
        check("model_idle", 32'(m_st), 32'(M_IDLE));

        // Composite memory write, then read back through command 0x02.
        scan_a(1'b1, 16'h0040, 16'hA5C3);
        scan_a(1'b0, 16'h0001, 16'h0003);
        scan_a(1'b1, 16'hBEEF, 16'h0040);
        scan_a(1'b0, 16'h0003, 16'h0003);
        check("mem_wr_count", 32'(m_wr_cnt), 32'd2);
        check("mem_wr_addr", 32'(m_wr_addr), 32'h0000_0040);
        check("mem_wr_data", 32'(m_wr_data), 32'h0000_BEEF);
        scan_a(1'b1, 16'h5555, 16'hBEEF);
        scan_a(1'b0, 16'h0002, 16'h0003);
        scan_a(1'b1, 16'h0000, 16'hBEEF);

        // Start held high during a whole DR scan, released in the done cycle.
        @(negedge clk);
        push_a(1'b1, 16'h1111, 16'h0000);
        a_if.i_isData = 1'b1;
        a_if.i_wrData = 16'h1111;
        a_if.i_start  = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (a_if.o_done) begin
                seen_done = 1'b1;
                break;
            end
        end
        a_if.i_start = 1'b0;
        check("held_start_done", 32'(seen_done), 32'd1);
        busy_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (a_if.o_busy) busy_seen++;
        end
        check("held_start_no_rescan", 32'(busy_seen), 32'd0);

        // Back-to-back: second request raised during the done cycle.
        scan_a(1'b1, 16'h2222, 16'h1111);
        issue_a(1'b0, 16'h0001, 16'h0003);
        check("b2b_accept_busy", 32'(a_if.o_busy), 32'd1);
        wait_done_a();
        check("b2b_model_addr", 32'(m_addr), 32'h0000_2222);

        // Reset during pulse 9 of a DR scan of 0xFFFF (TDI high at that point).
        @(negedge clk);
        a_if.i_isData = 1'b1;
        a_if.i_wrData = 16'hFFFF;
        a_if.i_start  = 1'b1;
        @(negedge clk);
        a_if.i_start  = 1'b0;
        rises = 0;
        prev_tck = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (a_if.o_TCK && !prev_tck) rises++;
            prev_tck = a_if.o_TCK;
            if (rises == 9) break;
            @(negedge clk);
        end
        check("pre_reset_pulse9", 32'(rises), 32'd9);
        check("pre_reset_tdi", 32'(a_if.o_TDI), 32'd1);
        check("pre_reset_busy", 32'(a_if.o_busy), 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        check("abort_tck", 32'(a_if.o_TCK), 32'd0);
        check("abort_tms", 32'(a_if.o_TMS), 32'd0);
        check("abort_tdi", 32'(a_if.o_TDI), 32'd0);
        check("abort_busy", 32'(a_if.o_busy), 32'd0);
        check("abort_rd", 32'(a_if.o_rdData), 32'd0);
        check("abort_state", 32'(a_if.o_state), 32'd0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        scan_a(1'b0, 16'h0001, 16'h0003);
        scan_a(1'b1, 16'h7E57, 16'h0000);
        scan_a(1'b1, 16'h0000, 16'h7E57);

        // CLK_DIV=1 instance, TDO tied high.
        scan_b(1'b0, 16'h005A, 16'h00FF, 16'd22);
        scan_b(1'b1, 16'h0F0F, 16'hFFFF, 16'd38);

        repeat (10) @(negedge clk);
        check("a_queue_empty", 32'(exp_q.size()), 32'd0);
        check("b_queue_empty", 32'(exp_b_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
